// File: rtl/wb_reg_poller_if.sv
// Wishbone classic bus bundle between the register poller (master) and the
// remote register slave. Signal names keep the Wishbone _o/_i affixes as seen
// from the initiator so they line up with the rest of the bus fabric.
interface wb_reg_poller_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic                    wb_we_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_ack_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;

  modport master (
    output wb_adr_o,
    output wb_dat_o,
    output wb_we_o,
    output wb_sel_o,
    output wb_cyc_o,
    output wb_stb_o,
    input  wb_ack_i,
    input  wb_dat_i
  );

  modport slave (
    input  wb_adr_o,
    input  wb_dat_o,
    input  wb_we_o,
    input  wb_sel_o,
    input  wb_cyc_o,
    input  wb_stb_o,
    output wb_ack_i,
    output wb_dat_i
  );
endinterface

// File: rtl/wb_reg_poller.sv
// wb_reg_poller: Wishbone classic single-read initiator that periodically
// reads one slave register at POLL_ADDR and keeps the last value returned,
// with valid / changed / timeout indications.
//
// Optional feature macro: WB_POLL_TIMEOUT_EN
//   defined   -> an access without ack for TIMEOUT_CYCLES strobe cycles is
//                abandoned and o_timeout pulses.
//   undefined -> an access waits for ack indefinitely; o_timeout is tied 0.
module wb_reg_poller #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] POLL_ADDR      = {ADDR_WIDTH{1'b0}},
  parameter int                    POLL_PERIOD    = 1000,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_poll_now,
  wb_reg_poller_if.master       bus,
  output logic [DATA_WIDTH-1:0] o_value,
  output logic                  o_valid,
  output logic                  o_changed,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int               CNT_W       = $clog2(POLL_PERIOD);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(POLL_PERIOD - 1);

  // Single-bit encoding: the state flop itself drives cyc/stb/busy, so the
  // bus strobe is a clean register output.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  pending_r;
  logic                  pending_nxt_s;
  logic [CNT_W-1:0]      period_cnt_r;
  logic                  tick_s;
  logic                  request_s;
  logic                  accept_s;
  logic                  abandon_s;
  logic                  changed_s;
  logic                  to_limit_s;
  logic [DATA_WIDTH-1:0] value_r;
  logic                  valid_r;
  logic                  changed_r;
  logic                  timeout_r;

  // Read-only initiator: address, write data, direction and byte lanes never change.
  assign bus.wb_adr_o = POLL_ADDR;
  assign bus.wb_dat_o = {DATA_WIDTH{1'b0}};
  assign bus.wb_we_o  = 1'b0;
  assign bus.wb_sel_o = {(DATA_WIDTH/8){1'b1}};

  assign bus.wb_cyc_o = (state_r == ACCESS);
  assign bus.wb_stb_o = (state_r == ACCESS);
  assign o_busy       = (state_r == ACCESS);

  assign o_value   = value_r;
  assign o_valid   = valid_r;
  assign o_changed = changed_r;
  assign o_timeout = timeout_r;

  // Tick on the POLL_PERIOD-th consecutive enabled cycle, independent of bus latency.
  assign tick_s    = i_enable && (period_cnt_r == {CNT_W{1'b0}});
  assign request_s = tick_s || i_poll_now;

  // Period counter: parked at the reload value while disabled, counts down while enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      period_cnt_r <= PERIOD_LOAD;
    end else if (!i_enable) begin
      period_cnt_r <= PERIOD_LOAD;
    end else if (period_cnt_r == {CNT_W{1'b0}}) begin
      period_cnt_r <= PERIOD_LOAD;
    end else begin
      period_cnt_r <= period_cnt_r - CNT_W'(1);
    end
  end

`ifdef WB_POLL_TIMEOUT_EN
  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_r;

  // The limit is reached during the TIMEOUT_CYCLES-th strobe cycle of an access.
  assign to_limit_s = (to_cnt_r == TO_LIMIT);

  // Count strobe cycles of the current access; cleared whenever the bus is idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r != ACCESS) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (!to_limit_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end
`else
  logic unused_timeout_s;

  // Without the timeout feature an access only ends on ack.
  assign to_limit_s       = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
`endif

  // Next-state, pending-request bookkeeping and access completion decode.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    accept_s      = 1'b0;
    abandon_s     = 1'b0;
    changed_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // A request in the launching cycle is absorbed by this access.
        if (request_s || pending_r) begin
          state_nxt_s   = ACCESS;
          pending_nxt_s = 1'b0;
        end else begin
          state_nxt_s   = IDLE;
          pending_nxt_s = 1'b0;
        end
      end
      ACCESS: begin
        // Requests during an access coalesce into one follow-up read.
        if (request_s) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
        // Ack wins over a timeout reached in the same cycle.
        if (bus.wb_ack_i) begin
          accept_s    = 1'b1;
          changed_s   = !valid_r || (bus.wb_dat_i != value_r);
          state_nxt_s = IDLE;
        end else if (to_limit_s) begin
          abandon_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // State and pending flag registers; reset drops the bus cycle immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Captured value, valid flag and one-cycle status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      value_r   <= {DATA_WIDTH{1'b0}};
      valid_r   <= 1'b0;
      changed_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      changed_r <= changed_s;
      timeout_r <= abandon_s;
      if (accept_s) begin
        value_r <= bus.wb_dat_i;
        valid_r <= 1'b1;
      end else begin
        value_r <= value_r;
        valid_r <= valid_r;
      end
    end
  end

endmodule

// File: tb/tb_wb_reg_poller.sv
// Self-checking bench for wb_reg_poller with POLL_PERIOD=8, TIMEOUT_CYCLES=16
// and a registered-ack slave whose ack latency can be stretched.
module tb_wb_reg_poller;
  localparam logic [31:0] P_ADDR = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        poll_now = 1'b0;
  logic [31:0] value;
  logic        valid, changed, busy, timeout;

  int checks = 0;
  int passed = 0;

  // expected observable state, updated from the read rules
  logic [31:0] exp_value = 32'h0;
  logic        exp_valid = 1'b0;

  // slave model
  logic [31:0] slave_reg = 32'h0;
  logic [31:0] junk = 32'hDEAD_BEEF;
  logic        ack_r = 1'b0;
  bit          ack_en = 1'b1;
  int          ack_lat = 0;
  int          wait_cnt = 0;

  wb_reg_poller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  wb_reg_poller #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .POLL_ADDR(P_ADDR),
    .POLL_PERIOD(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_poll_now(poll_now),
    .bus(bus), .o_value(value), .o_valid(valid), .o_changed(changed),
    .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // registered ack after ack_lat extra wait states; data valid only with ack
  always @(posedge clk) begin
    junk <= $urandom();
    if (bus.wb_stb_o && !ack_r) begin
      ack_r    <= ack_en && (wait_cnt >= ack_lat);
      wait_cnt <= wait_cnt + 1;
    end else begin
      ack_r    <= 1'b0;
      wait_cnt <= 0;
    end
  end
  assign bus.wb_ack_i = ack_r;
  assign bus.wb_dat_i = ack_r ? slave_reg : junk;

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable   = 1'($urandom());
      poll_now = 1'($urandom());
      @(negedge clk);
    end
    checks++; if (bus.wb_stb_o !== 1'b0) $display("FAIL reset_stb got=%b exp=0", bus.wb_stb_o); else passed++;
    checks++; if (bus.wb_cyc_o !== 1'b0) $display("FAIL reset_cyc got=%b exp=0", bus.wb_cyc_o); else passed++;
    checks++; if (value !== 32'h0) $display("FAIL reset_value got=%h exp=0", value); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passed++;
    checks++; if (changed !== 1'b0) $display("FAIL reset_changed got=%b exp=0", changed); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else passed++;
    checks++; if (bus.wb_adr_o !== P_ADDR) $display("FAIL reset_adr got=%h exp=%h", bus.wb_adr_o, P_ADDR); else passed++;
    checks++; if (bus.wb_dat_o !== 32'h0) $display("FAIL reset_dat_o got=%h exp=0", bus.wb_dat_o); else passed++;
    checks++; if (bus.wb_we_o !== 1'b0) $display("FAIL reset_we got=%b exp=0", bus.wb_we_o); else passed++;
    checks++; if (bus.wb_sel_o !== 4'hF) $display("FAIL reset_sel got=%h exp=f", bus.wb_sel_o); else passed++;
    enable = 1'b0; poll_now = 1'b0; rst = 1'b0;
    exp_value = 32'h0; exp_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.wb_stb_o !== 1'b0) $display("FAIL post_reset_stb got=%b exp=0", bus.wb_stb_o); else passed++;
  endtask

  // periodic polls: stb high on enabled cycles 8k and 8k+1 after enable rises
  task automatic test_periodic();
    int   npoll = 6;
    logic exp_stb, exp_chg;
    slave_reg = 32'hA5A5_0001;
    enable = 1'b1;
    for (int n = 1; n <= 8 * npoll + 2; n++) begin
      @(negedge clk);
      exp_stb = (n >= 8) && ((n % 8 == 0) || (n % 8 == 1));
      exp_chg = 1'b0;
      if (n >= 10 && n % 8 == 2) begin
        exp_chg   = !exp_valid || (slave_reg != exp_value);
        exp_value = slave_reg;
        exp_valid = 1'b1;
      end
      checks++; if (bus.wb_stb_o !== exp_stb) $display("FAIL periodic_stb n=%0d got=%b exp=%b", n, bus.wb_stb_o, exp_stb); else passed++;
      checks++; if (busy !== exp_stb) $display("FAIL periodic_busy n=%0d got=%b exp=%b", n, busy, exp_stb); else passed++;
      checks++; if (value !== exp_value) $display("FAIL periodic_value n=%0d got=%h exp=%h", n, value, exp_value); else passed++;
      checks++; if (valid !== exp_valid) $display("FAIL periodic_valid n=%0d got=%b exp=%b", n, valid, exp_valid); else passed++;
      checks++; if (changed !== exp_chg) $display("FAIL periodic_changed n=%0d got=%b exp=%b", n, changed, exp_chg); else passed++;
      if (n % 8 == 4) begin
        if (n == 20) slave_reg = 32'h0000_0002;
        else if (n > 20 && $urandom_range(0, 1) == 1) slave_reg = $urandom();
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  // two poll_now pulses during a stretched access give exactly one follow-up access
  task automatic test_pending();
    int   lat, starts;
    logic exp_stb, exp_chg, prev_stb;
    lat = $urandom_range(3, 5);
    ack_lat = lat;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    slave_reg = $urandom();
    starts = 0; prev_stb = 1'b0;
    poll_now = 1'b1;
    for (int j = 1; j <= 2 * lat + 10; j++) begin
      @(negedge clk);
      poll_now = (j == 2) || (j == 4);
      exp_stb = (j <= lat + 2) || (j >= lat + 4 && j <= 2 * lat + 5);
      exp_chg = 1'b0;
      if (j == lat + 3 || j == 2 * lat + 6) begin
        exp_chg   = !exp_valid || (slave_reg != exp_value);
        exp_value = slave_reg;
        exp_valid = 1'b1;
      end
      checks++; if (bus.wb_stb_o !== exp_stb) $display("FAIL pending_stb j=%0d lat=%0d got=%b exp=%b", j, lat, bus.wb_stb_o, exp_stb); else passed++;
      checks++; if (changed !== exp_chg) $display("FAIL pending_changed j=%0d got=%b exp=%b", j, changed, exp_chg); else passed++;
      checks++; if (value !== exp_value) $display("FAIL pending_value j=%0d got=%h exp=%h", j, value, exp_value); else passed++;
      if (bus.wb_stb_o === 1'b1 && prev_stb === 1'b0) starts++;
      prev_stb = bus.wb_stb_o;
    end
    checks++; if (starts !== 2) $display("FAIL pending_accesses got=%0d exp=2", starts); else passed++;
    ack_lat = 0;
  endtask

  // silent slave, then an ack arriving exactly at the timeout limit
  task automatic test_timeout();
    logic exp_stb, exp_chg;
`ifndef WB_POLL_TIMEOUT_EN
    int hi, tos;
`endif
    ack_en = 1'b0;
    poll_now = 1'b1;
`ifdef WB_POLL_TIMEOUT_EN
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      poll_now = 1'b0;
      exp_stb = (j <= 16);
      checks++; if (bus.wb_stb_o !== exp_stb) $display("FAIL timeout_stb j=%0d got=%b exp=%b", j, bus.wb_stb_o, exp_stb); else passed++;
      checks++; if (timeout !== (j == 17)) $display("FAIL timeout_pulse j=%0d got=%b exp=%b", j, timeout, (j == 17)); else passed++;
      checks++; if (value !== exp_value) $display("FAIL timeout_value j=%0d got=%h exp=%h", j, value, exp_value); else passed++;
      checks++; if (changed !== 1'b0) $display("FAIL timeout_changed j=%0d got=%b exp=0", j, changed); else passed++;
    end
`else
    hi = 0; tos = 0;
    for (int j = 1; j <= 1000; j++) begin
      @(negedge clk);
      poll_now = 1'b0;
      if (bus.wb_stb_o === 1'b1) hi++;
      if (timeout !== 1'b0) tos++;
    end
    checks++; if (hi !== 1000) $display("FAIL hang_stb_cycles got=%0d exp=1000", hi); else passed++;
    checks++; if (tos !== 0) $display("FAIL hang_timeout got=%0d exp=0", tos); else passed++;
    checks++; if (value !== exp_value) $display("FAIL hang_value got=%h exp=%h", value, exp_value); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_value = 32'h0; exp_valid = 1'b0;
    checks++; if (bus.wb_stb_o !== 1'b0) $display("FAIL hang_reset_stb got=%b exp=0", bus.wb_stb_o); else passed++;
`endif
    ack_en = 1'b1;
    ack_lat = 14;
    slave_reg = $urandom();
    poll_now = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      @(negedge clk);
      poll_now = 1'b0;
      exp_stb = (j <= 16);
      exp_chg = 1'b0;
      if (j == 17) begin
        exp_chg   = !exp_valid || (slave_reg != exp_value);
        exp_value = slave_reg;
        exp_valid = 1'b1;
      end
      checks++; if (bus.wb_stb_o !== exp_stb) $display("FAIL limit_ack_stb j=%0d got=%b exp=%b", j, bus.wb_stb_o, exp_stb); else passed++;
      checks++; if (timeout !== 1'b0) $display("FAIL limit_ack_timeout j=%0d got=%b exp=0", j, timeout); else passed++;
      checks++; if (value !== exp_value) $display("FAIL limit_ack_value j=%0d got=%h exp=%h", j, value, exp_value); else passed++;
      checks++; if (changed !== exp_chg) $display("FAIL limit_ack_changed j=%0d got=%b exp=%b", j, changed, exp_chg); else passed++;
    end
    ack_lat = 0;
  endtask

  // reset in the first strobe cycle, then the tick restarts from a full period
  task automatic test_reset_mid();
    bit   seen;
    logic exp_stb, exp_chg;
    slave_reg = $urandom();
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.wb_stb_o === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) $display("FAIL reset_mid_wait_stb got=no_stb exp=stb within 20 cycles"); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_value = 32'h0; exp_valid = 1'b0;
    checks++; if (bus.wb_stb_o !== 1'b0) $display("FAIL reset_mid_stb got=%b exp=0", bus.wb_stb_o); else passed++;
    checks++; if (bus.wb_cyc_o !== 1'b0) $display("FAIL reset_mid_cyc got=%b exp=0", bus.wb_cyc_o); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_mid_valid got=%b exp=0", valid); else passed++;
    checks++; if (changed !== 1'b0) $display("FAIL reset_mid_changed got=%b exp=0", changed); else passed++;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      exp_stb = (j == 8) || (j == 9);
      exp_chg = 1'b0;
      if (j == 10) begin
        exp_chg   = 1'b1;
        exp_value = slave_reg;
        exp_valid = 1'b1;
      end
      checks++; if (bus.wb_stb_o !== exp_stb) $display("FAIL after_reset_stb j=%0d got=%b exp=%b", j, bus.wb_stb_o, exp_stb); else passed++;
      checks++; if (valid !== exp_valid) $display("FAIL after_reset_valid j=%0d got=%b exp=%b", j, valid, exp_valid); else passed++;
      checks++; if (changed !== exp_chg) $display("FAIL after_reset_changed j=%0d got=%b exp=%b", j, changed, exp_chg); else passed++;
      checks++; if (value !== exp_value) $display("FAIL after_reset_value j=%0d got=%h exp=%h", j, value, exp_value); else passed++;
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_pending();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
